mem_access_stage: RTL
=====================

Name:
mem_access_stage

Overview:
- MEM stage of the 8-bit pipelined core. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Runs loads and stores on a req/ack data-memory bus with variable latency, stalls the upstream pipeline while an access is outstanding, resolves branches, and registers the MEM/WB fields.

Parameters:
TIMEOUT_CYCLES, 16, WAIT cycles without dmem_ack before the access is aborted with a bus error (legal range 2..255).

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
ex_alu_result  input  8  EX/MEM ALU result; memory address for loads and stores
ex_rd2  input  8  EX/MEM store data
ex_rd  input  3  EX/MEM destination register
ex_zero  input  1  EX/MEM zero flag
ex_memread  input  1  load
ex_memwrite  input  1  store
ex_memtoreg  input  1  write-back source select
ex_regwrite  input  1  register write enable
ex_branch  input  1  branch instruction
dmem_req  output  1  memory request, registered
dmem_we  output  1  1=write, 0=read, registered
dmem_addr  output  8  registered address
dmem_wdata  output  8  registered write data
dmem_rdata  input  8  read data, sampled on dmem_ack
dmem_ack  input  1  single-cycle completion pulse
stall_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
pc_src_o  output  1  branch taken (combinational)
bus_err_o  output  1  sticky timeout error
wb_read_data  output  8  MEM/WB load data
wb_alu_result  output  8  MEM/WB ALU result
wb_rd  output  3  MEM/WB destination register
wb_memtoreg  output  1  MEM/WB memtoreg
wb_regwrite  output  1  MEM/WB regwrite

Behaviour:
- Reset: all registered outputs 0, state IDLE, timeout counter 0. Reset asserted mid-access drops dmem_req immediately and discards the access.
- FSM states: IDLE, WAIT, DONE. Let acc = ex_memread | ex_memwrite.
- IDLE with acc=0:
  - MEM/WB loads every cycle: wb_alu_result=ex_alu_result, wb_rd=ex_rd, wb_memtoreg=ex_memtoreg, wb_regwrite=ex_regwrite, wb_read_data=0.
  - stall_o=0.
- IDLE with acc=1:
  - stall_o=1.
  - dmem_req<=1, dmem_addr<=ex_alu_result, dmem_wdata<=ex_rd2, dmem_we<=~ex_memread (read wins if both are set).
  - MEM/WB loads a bubble: wb_regwrite=0, wb_memtoreg=0, other fields 0.
  - Counter<=0. Next state WAIT.
- WAIT:
  - stall_o=1. dmem_req and the bus fields are held stable. MEM/WB holds the bubble. Counter increments each cycle.
  - On dmem_ack: capture dmem_rdata (or 0 for a write), dmem_req<=0, next state DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack: dmem_req<=0, captured data=0, bus_err_o<=1, next state DONE.
  - Ack in the same cycle as timeout: ack wins, no error.
- DONE:
  - stall_o=0, so upstream advances this edge.
  - MEM/WB loads the held ex_* fields, with wb_read_data = captured data for loads, 0 for stores.
  - Next state IDLE. dmem_ack is ignored outside WAIT.
- Minimum occupancy of a memory instruction = (ack latency) + 2 cycles. Back-to-back memory instructions each re-enter the IDLE→WAIT→DONE sequence.
- pc_src_o = ex_branch & ex_zero & (state==IDLE) & ~acc.
- bus_err_o stays set until reset.

Test Plan:
- ALU op: ex_alu_result=8'h3C, ex_rd=5, ex_regwrite=1, acc=0 → next edge wb_alu_result=8'h3C, wb_rd=5, wb_regwrite=1; stall_o=0 throughout.
- Load addr 8'h20, dmem_ack asserted 3 cycles after dmem_req, dmem_rdata=8'hA5 → dmem_addr=8'h20, dmem_we=0; stall_o high 4 cycles; DONE gives wb_read_data=8'hA5, wb_memtoreg=1; dmem_req low after ack.
- Store addr 8'h10, data 8'h5A, ack on the first WAIT cycle → dmem_we=1, dmem_wdata=8'h5A; stall_o high 2 cycles; wb_regwrite=0; bus_err_o=0.
- Load with no ack, default TIMEOUT_CYCLES=16 → dmem_req drops after 16 WAIT cycles; bus_err_o=1 and sticky; wb_read_data=0; pipeline resumes. Repeat with ack on cycle 16 → no error.
- Branch with ex_branch=1, ex_zero=1, acc=0 → pc_src_o=1; same inputs during WAIT → pc_src_o=0.
- reset_n low during WAIT → dmem_req, stall_o, and all wb_* outputs 0 asynchronously; after release, a fresh load completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 8-bit pipelined core.
//   Issues loads/stores on a req/ack data bus and stalls upstream while an access is outstanding.
//   Aborts an access with a sticky bus error after TIMEOUT_CYCLES wait cycles, resolves branches,
//   and registers the MEM/WB fields.
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   ex_*                  EX/MEM pipeline register outputs
//   dmem_req/we/addr/wdata registered bus request; dmem_rdata/dmem_ack bus response
//   stall_o, pc_src_o     combinational pipeline freeze and branch-taken
//   bus_err_o             sticky timeout error
//   wb_*                  MEM/WB pipeline register
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ex_alu_result,
    input  logic [7:0] ex_rd2,
    input  logic [2:0] ex_rd,
    input  logic       ex_zero,
    input  logic       ex_memread,
    input  logic       ex_memwrite,
    input  logic       ex_memtoreg,
    input  logic       ex_regwrite,
    input  logic       ex_branch,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    input  logic [7:0] dmem_rdata,
    input  logic       dmem_ack,
    output logic       stall_o,
    output logic       pc_src_o,
    output logic       bus_err_o,
    output logic [7:0] wb_read_data,
    output logic [7:0] wb_alu_result,
    output logic [2:0] wb_rd,
    output logic       wb_memtoreg,
    output logic       wb_regwrite
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cap_q, cap_d;
    logic       req_q, req_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       err_q, err_d;
    logic [7:0] wb_read_data_q, wb_read_data_d;
    logic [7:0] wb_alu_result_q, wb_alu_result_d;
    logic [2:0] wb_rd_q, wb_rd_d;
    logic       wb_memtoreg_q, wb_memtoreg_d;
    logic       wb_regwrite_q, wb_regwrite_d;
    logic       acc;

    assign acc = ex_memread | ex_memwrite;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cap_d           = cap_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        err_d           = err_q;
        wb_read_data_d  = wb_read_data_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_rd_d         = wb_rd_q;
        wb_memtoreg_d   = wb_memtoreg_q;
        wb_regwrite_d   = wb_regwrite_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    req_d           = 1'b1;
                    we_d            = ~ex_memread;
                    addr_d          = ex_alu_result;
                    wdata_d         = ex_rd2;
                    cnt_d           = 8'd0;
                    cap_d           = 8'd0;
                    wb_read_data_d  = 8'd0;
                    wb_alu_result_d = 8'd0;
                    wb_rd_d         = 3'd0;
                    wb_memtoreg_d   = 1'b0;
                    wb_regwrite_d   = 1'b0;
                    state_d         = WAIT;
                end else begin
                    wb_read_data_d  = 8'd0;
                    wb_alu_result_d = ex_alu_result;
                    wb_rd_d         = ex_rd;
                    wb_memtoreg_d   = ex_memtoreg;
                    wb_regwrite_d   = ex_regwrite;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // ack takes priority over a timeout landing in the same cycle
                if (dmem_ack) begin
                    cap_d   = we_q ? 8'd0 : dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    cap_d   = 8'd0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // EX/MEM was frozen throughout, so ex_* still describe this access
                wb_read_data_d  = cap_q;
                wb_alu_result_d = ex_alu_result;
                wb_rd_d         = ex_rd;
                wb_memtoreg_d   = ex_memtoreg;
                wb_regwrite_d   = ex_regwrite;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            cap_q           <= 8'd0;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= 8'd0;
            wdata_q         <= 8'd0;
            err_q           <= 1'b0;
            wb_read_data_q  <= 8'd0;
            wb_alu_result_q <= 8'd0;
            wb_rd_q         <= 3'd0;
            wb_memtoreg_q   <= 1'b0;
            wb_regwrite_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cap_q           <= cap_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            err_q           <= err_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_rd_q         <= wb_rd_d;
            wb_memtoreg_q   <= wb_memtoreg_d;
            wb_regwrite_q   <= wb_regwrite_d;
        end
    end

    // gated by reset_n so the pipeline is released while reset is held
    assign stall_o       = reset_n & ((state_q == IDLE & acc) | (state_q == WAIT));
    assign pc_src_o      = ex_branch & ex_zero & (state_q == IDLE) & ~acc;
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign bus_err_o     = err_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_rd         = wb_rd_q;
    assign wb_memtoreg   = wb_memtoreg_q;
    assign wb_regwrite   = wb_regwrite_q;
endmodule
